regfile_mp: RTL and testbench

Parametrised multi-port integer register file with per-register pending-write scoreboard, the successor to the single-entry write-merge logic in the datapath. It holds 2**REG_LOG architectural registers of DATA_WIDTH bits. It accepts NUM_WR writeback ports per cycle and serves NUM_RD registered read ports with same-cycle write bypass. It sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Writes resolve highest-port-wins; reads are registered and bypass same-cycle writes.
module regfile_mp #(
    parameter int REG_LOG    = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR-1:0][REG_LOG-1:0]        wr_sel,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wr_data,
    input  logic [NUM_RD-1:0]                     rd_en,
    input  logic [NUM_RD-1:0][REG_LOG-1:0]        rd_sel,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_RD-1:0]                     rd_busy,
    output logic [NUM_RD-1:0]                     rd_valid,
    input  logic                                  mark_en,
    input  logic [REG_LOG-1:0]                    mark_sel,
    output logic [(1<<REG_LOG)-1:0]               busy_vec
);

    localparam int NREG = 1 << REG_LOG;

    logic [DATA_WIDTH-1:0]              regs_q [NREG];
    logic [DATA_WIDTH-1:0]              regs_d [NREG];
    logic [NREG-1:0]                    busy_q, busy_d;
    logic [NREG-1:0]                    wr_hit, mark_hit;

    logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]                  rd_busy_q, rd_busy_d;
    logic [NUM_RD-1:0]                  rd_valid_q;

    // Post-edge view of storage and scoreboard; the read path taps these for bypass.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        regs_d   = regs_q;
        wr_hit   = '0;
        mark_hit = '0;
        for (int i = 0; i < NREG; i++) begin
            // Later ports overwrite earlier ones, giving highest-index-wins.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_sel[p] == REG_LOG'(i))) begin
                    wr_hit[i] = 1'b1;
                    regs_d[i] = wr_data[p];
                end
            end
        end
        if (mark_en) begin
            mark_hit[mark_sel] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            wr_hit[0]   = 1'b0;
            mark_hit[0] = 1'b0;
            regs_d[0]   = '0;
        end
        // A new producer supersedes the one completing this cycle.
        busy_d = (busy_q & ~wr_hit) | mark_hit;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_en[r]) begin
                rd_data_d[r] = regs_d[rd_sel[r]];
                rd_busy_d[r] = busy_d[rd_sel[r]];
            end
        end
    end

    // NOTE: the storage array is reset too, because every register must read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp in a 16 x 32-bit, 4-read, 3-write, zero-register configuration.
module tb_regfile_mp;

    localparam int RL = 4;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 3;

    logic                    clk;
    logic                    reset_n;
    logic [NW-1:0]           wr_en;
    logic [NW-1:0][RL-1:0]   wr_sel;
    logic [NW-1:0][DW-1:0]   wr_data;
    logic [NR-1:0]           rd_en;
    logic [NR-1:0][RL-1:0]   rd_sel;
    logic [NR-1:0][DW-1:0]   rd_data;
    logic [NR-1:0]           rd_busy;
    logic [NR-1:0]           rd_valid;
    logic                    mark_en;
    logic [RL-1:0]           mark_sel;
    logic [(1<<RL)-1:0]      busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(
        .REG_LOG(RL), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .mark_en(mark_en), .mark_sel(mark_sel), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic [NW-1:0]         we;
        logic [NW*RL-1:0]      ws;
        logic [NW*DW-1:0]      wd;
        logic [NR-1:0]         re;
        logic [NR*RL-1:0]      rs;
        logic                  me;
        logic [RL-1:0]         ms;
        logic [NR*DW-1:0]      exp_data;
        logic [NR-1:0]         exp_busy;
        logic [NR-1:0]         exp_valid;
        logic [(1<<RL)-1:0]    exp_bvec;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_sel = '0; wr_data = '0;
        rd_en = '0; rd_sel = '0;
        mark_en = 1'b0; mark_sel = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(string n, logic [NW-1:0] we, logic [NW*RL-1:0] ws,
                                logic [NW*DW-1:0] wd, logic [NR-1:0] re, logic [NR*RL-1:0] rs,
                                logic me, logic [RL-1:0] ms, logic [NR*DW-1:0] ed,
                                logic [NR-1:0] eb, logic [NR-1:0] ev, logic [(1<<RL)-1:0] bv);
        vec_t v;
        v.name = n; v.we = we; v.ws = ws; v.wd = wd; v.re = re; v.rs = rs;
        v.me = me; v.ms = ms; v.exp_data = ed; v.exp_busy = eb; v.exp_valid = ev;
        v.exp_bvec = bv;
        return v;
    endfunction

    initial begin
        // Fields: name, wr_en, wr_sel{p2,p1,p0}, wr_data{p2,p1,p0}, rd_en, rd_sel{p3..p0},
        // mark_en, mark_sel, exp rd_data{p3..p0}, exp rd_busy, exp rd_valid, exp busy_vec.
        vt[0]  = mk("wr3",       3'b001, 12'h003, {32'h0, 32'h0, 32'h1234},    4'b0000, 16'h0000, 1'b0, 4'd0,
                    {64'h0, 32'h0, 32'h0},       4'b0000, 4'b0000, 16'h0000);
        vt[1]  = mk("rd3",       3'b000, 12'h000, 96'h0,                       4'b0001, 16'h0003, 1'b0, 4'd0,
                    {64'h0, 32'h0, 32'h1234},    4'b0000, 4'b0001, 16'h0000);
        vt[2]  = mk("bypass_p1", 3'b011, 12'h055, {32'h0, 32'hBB, 32'hAA},     4'b0001, 16'h0005, 1'b0, 4'd0,
                    {64'h0, 32'h0, 32'hBB},      4'b0000, 4'b0001, 16'h0000);
        vt[3]  = mk("store5",    3'b000, 12'h000, 96'h0,                       4'b0010, 16'h0050, 1'b0, 4'd0,
                    {64'h0, 32'hBB, 32'hBB},     4'b0000, 4'b0010, 16'h0000);
        vt[4]  = mk("bypass_p2", 3'b111, 12'h666, {32'h33, 32'h22, 32'h11},    4'b0001, 16'h0006, 1'b0, 4'd0,
                    {64'h0, 32'hBB, 32'h33},     4'b0000, 4'b0001, 16'h0000);
        vt[5]  = mk("mark9",     3'b000, 12'h000, 96'h0,                       4'b0001, 16'h0009, 1'b1, 4'd9,
                    {64'h0, 32'hBB, 32'h0},      4'b0001, 4'b0001, 16'h0200);
        vt[6]  = mk("idle",      3'b000, 12'h000, 96'h0,                       4'b0000, 16'h0000, 1'b0, 4'd0,
                    {64'h0, 32'hBB, 32'h0},      4'b0001, 4'b0000, 16'h0200);
        vt[7]  = mk("wr_mark9",  3'b001, 12'h009, {32'h0, 32'h0, 32'h99},      4'b0010, 16'h0090, 1'b1, 4'd9,
                    {64'h0, 32'h99, 32'h0},      4'b0011, 4'b0010, 16'h0200);
        vt[8]  = mk("clr9",      3'b010, 12'h090, {32'h0, 32'h9A, 32'h0},      4'b0001, 16'h0009, 1'b0, 4'd0,
                    {64'h0, 32'h99, 32'h9A},     4'b0010, 4'b0001, 16'h0000);
        vt[9]  = mk("zero_reg",  3'b001, 12'h000, {32'h0, 32'h0, 32'hFF},      4'b0011, 16'h0000, 1'b1, 4'd0,
                    {64'h0, 32'h0, 32'h0},       4'b0000, 4'b0011, 16'h0000);
        vt[10] = mk("zero_mix",  3'b101, 12'h001, {32'hFF, 32'h0, 32'h101},    4'b0011, 16'h0010, 1'b0, 4'd0,
                    {64'h0, 32'h101, 32'h0},     4'b0000, 4'b0011, 16'h0000);
        vt[11] = mk("mark3_wr4", 3'b100, 12'h400, {32'h44, 32'h0, 32'h0},      4'b0011, 16'h0043, 1'b1, 4'd3,
                    {64'h0, 32'h44, 32'h1234},   4'b0001, 4'b0011, 16'h0008);
        vt[12] = mk("clr3",      3'b010, 12'h030, {32'h0, 32'h3333, 32'h0},    4'b0001, 16'h0003, 1'b0, 4'd0,
                    {64'h0, 32'h44, 32'h3333},   4'b0000, 4'b0001, 16'h0000);

        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset_data",  128'(rd_data),  128'h0);
        check("reset_valid", 128'(rd_valid), 128'h0);
        check("reset_bvec",  128'(busy_vec), 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Preload reg 7, then knock it out with an asynchronous mid-cycle reset.
        wr_en = 3'b001; wr_sel[0] = 4'd7; wr_data[0] = 32'hDEAD;
        mark_en = 1'b1; mark_sel = 4'd2;
        step();
        idle_inputs();
        rd_en = 4'b0011; rd_sel[0] = 4'd7; rd_sel[1] = 4'd2;
        step();
        check("pre_rst_data",  128'(rd_data[0]), 128'hDEAD);
        check("pre_rst_busy",  128'(rd_busy),    128'h2);
        check("pre_rst_bvec",  128'(busy_vec),   128'h0004);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_data",  128'(rd_data),  128'h0);
        check("async_valid", 128'(rd_valid), 128'h0);
        check("async_busy",  128'(rd_busy),  128'h0);
        check("async_bvec",  128'(busy_vec), 128'h0);
        wr_en = 3'b001; wr_sel[0] = 4'd4; wr_data[0] = 32'h55;
        mark_en = 1'b1; mark_sel = 4'd4; rd_en = 4'b1111;
        step();
        check("in_rst_valid", 128'(rd_valid), 128'h0);
        check("in_rst_bvec",  128'(busy_vec), 128'h0);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        step();
        rd_en = 4'b0011; rd_sel[0] = 4'd7; rd_sel[1] = 4'd4;
        step();
        check("post_rst_data",  128'(rd_data),  128'h0);
        check("post_rst_valid", 128'(rd_valid), 128'h3);
        check("post_rst_bvec",  128'(busy_vec), 128'h0);

        for (int i = 0; i < 13; i++) begin
            wr_en = vt[i].we; wr_sel = vt[i].ws; wr_data = vt[i].wd;
            rd_en = vt[i].re; rd_sel = vt[i].rs;
            mark_en = vt[i].me; mark_sel = vt[i].ms;
            step();
            check({vt[i].name, "_data"},  128'(rd_data),  128'(vt[i].exp_data));
            check({vt[i].name, "_busy"},  128'(rd_busy),  128'(vt[i].exp_busy));
            check({vt[i].name, "_valid"}, 128'(rd_valid), 128'(vt[i].exp_valid));
            check({vt[i].name, "_bvec"},  128'(busy_vec), 128'(vt[i].exp_bvec));
        end

        // All four read ports on reg 15, then idle ports must hold their data.
        idle_inputs();
        wr_en = 3'b100; wr_sel[2] = 4'd15; wr_data[2] = 32'hCAFEF00D;
        step();
        idle_inputs();
        rd_en = 4'b1111; rd_sel = 16'hFFFF;
        step();
        check("all_rd_data",  128'(rd_data),  {4{32'hCAFEF00D}});
        check("all_rd_valid", 128'(rd_valid), 128'hF);
        check("all_rd_busy",  128'(rd_busy),  128'h0);
        idle_inputs();
        wr_en = 3'b001; wr_sel[0] = 4'd15; wr_data[0] = 32'h0;
        step();
        check("hold_data",  128'(rd_data),  {4{32'hCAFEF00D}});
        check("hold_valid", 128'(rd_valid), 128'h0);
        idle_inputs();
        rd_en = 4'b0001; rd_sel[0] = 4'd15;
        step();
        check("reread15_data",  128'(rd_data),  {{3{32'hCAFEF00D}}, 32'h0});
        check("reread15_valid", 128'(rd_valid), 128'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
